lsu_stage: RTL
==============

Name: lsu_stage

Overview:
Memory-access stage directly downstream of the execute unit. It consumes the execute result (ALU result, rd address/enable, store data, memory control) and performs at most one load or store per instruction over a simple valid/ready data bus. It formats store strobes and data, and aligns and extends load data. It presents a writeback message to the writeback stage over a valid/ready handshake. Non-memory instructions pass through with one-cycle latency.

Parameters:
- WIDTH, 32, datapath/address width; only 32 is supported, byte lanes = WIDTH/8 = 4.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept; high only in IDLE
- in_alu_result  in  WIDTH  effective address (mem ops) or rd value (others)
- in_store_data  in  WIDTH  rs2 value for stores
- in_rf_waddr  in  5  destination register
- in_rf_we  in  1  register write enable
- in_mem_re  in  1  load
- in_mem_we  in  1  store; in_mem_re and in_mem_we are never both 1
- in_mem_size  in  2  0=byte, 1=half, 2=word
- in_mem_unsigned  in  1  zero-extend load (lbu/lhu)
- in_pc  in  WIDTH  debug pc
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  WIDTH  full byte address
- mem_req_wen  out  1  1=write
- mem_req_wdata  out  WIDTH  lane-replicated store data
- mem_req_wstrb  out  WIDTH/8  byte strobes; 0 for reads
- mem_rsp_valid  in  1  read data / write ack
- mem_rsp_rdata  in  WIDTH  aligned 32-bit word
- out_valid  out  1  writeback message valid
- out_ready  in  1  writeback stage accepts
- out_rf_waddr  out  5
- out_rf_we  out  1
- out_rf_wdata  out  WIDTH
- out_pc  out  WIDTH
- out_misalign  out  1  misaligned access flagged

Behaviour:
- States: IDLE, REQ, WAIT, DONE. On reset: state=IDLE; in_ready=1; mem_req_valid=0; out_valid=0; all other registered outputs 0.
- IDLE: in_ready=1. On in_valid, capture all inputs.
  - Non-memory op: out_rf_wdata=in_alu_result, then go to DONE.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): out_misalign=1, out_rf_we=0, no bus request, go to DONE.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1 with addr/wen/wdata/wstrb held stable until mem_req_ready. On handshake go to WAIT; mem_req_valid drops the next cycle.
- WAIT: on mem_rsp_valid go to DONE.
  - Load: capture aligned/extended data into out_rf_wdata.
  - Store: out_rf_we forced 0.
- mem_rsp_valid outside WAIT is ignored. The bus must not respond in the same cycle as its request handshake.
- DONE: out_valid=1, outputs stable. On out_ready, go to IDLE; out_valid drops and in_ready rises the next cycle.
- Latency from in handshake to out_valid:
  - Non-memory or misaligned: 1 cycle.
  - Memory: 2 cycles plus request-stall cycles plus response wait cycles.
- Throughput: at most one instruction in flight. A new input is not accepted in the same cycle as an out handshake.
- Store format:
  - Byte: strobe = 1 << addr[1:0]; wdata = byte replicated to 4 lanes.
  - Half: strobe = 0011 << (2*addr[1]); wdata = half replicated to 2 lanes.
  - Word: strobe = 1111; wdata unchanged.
- Load align: shift rdata right by 8*addr[1:0]. Take the low byte/half/word, then sign-extend, or zero-extend when unsigned. mem_size=3 is treated as word.
- out_misalign is cleared on the next input capture.
- Reset mid-operation (any state): the next cycle is IDLE with all outputs at reset values. The in-flight request/response is dropped; the bus slave shares rst.

Decomposition:
- Shared package holds:
  - mem_size encodings (SZ_B=0, SZ_H=1, SZ_W=2)
  - the 2-bit state encoding
  - the byte-lane count constant
- One combinational sub-module, lsu_align, contains both the store formatter (wdata/wstrb) and the load extractor/extender.

Test Plan:
- lb from addr 0x80000003, rdata 0x80AABBCC, mem_req_ready=1, rsp 1 cycle later -> out_rf_wdata=0xFFFFFF80, out_rf_we=1, out_valid 3 cycles after input handshake.
- sh addr 0x80000002, data 0x1234ABCD -> wstrb=1100, wdata=0xABCDABCD, wen=1; after ack out_rf_we=0.
- lw addr 0x80000006 -> no mem_req_valid ever; out_misalign=1, out_rf_we=0, out_valid next cycle.
- Non-memory, alu_result 0x42, out_ready held low 5 cycles -> out_valid held with stable data, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
- lbu addr 0x1, mem_req_ready low 3 cycles -> request fields stable while stalled; rdata 0x0000F000 -> out_rf_wdata=0x000000F0.
- rst asserted in WAIT -> next cycle mem_req_valid=0, out_valid=0, in_ready=1; a late mem_rsp_valid is ignored.

Source files
------------

// File: rtl/lsu_stage_pkg.sv
// lsu_stage_pkg: shared definitions for the load/store stage.
//   - memory access size encodings (SZ_B/SZ_H/SZ_W; 3 behaves as word)
//   - 2-bit FSM state encoding
//   - datapath width and byte-lane count
//   - is_misaligned(): natural-alignment check for a given size/address
package lsu_stage_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned NumLanes = DataW / 8;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } lsu_state_e;

  // Any size other than byte/half is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// lsu_stage_if: simple valid/ready data-bus between the load/store stage and memory.
//   mem_req_valid/ready  request handshake
//   mem_req_addr         full byte address
//   mem_req_wen          1 = write
//   mem_req_wdata        lane-replicated store data
//   mem_req_wstrb        byte strobes, 0 for reads
//   mem_rsp_valid        read data / write acknowledge
//   mem_rsp_rdata        aligned 32-bit word
// Modports: master = load/store stage, slave = memory.
interface lsu_stage_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [WIDTH-1:0]   mem_req_addr;
  logic               mem_req_wen;
  logic [WIDTH-1:0]   mem_req_wdata;
  logic [WIDTH/8-1:0] mem_req_wstrb;
  logic               mem_rsp_valid;
  logic [WIDTH-1:0]   mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane formatting for the load/store stage.
//   Store side: i_st_addr_lo/i_st_size/i_st_data -> o_st_wdata (lane-replicated), o_st_wstrb
//   Load side:  i_ld_addr_lo/i_ld_size/i_ld_unsigned/i_ld_rdata -> o_ld_data (aligned, extended)
module lsu_align
  import lsu_stage_pkg::*;
(
  input  logic [1:0]          i_st_addr_lo,
  input  logic [1:0]          i_st_size,
  input  logic [DataW-1:0]    i_st_data,
  output logic [DataW-1:0]    o_st_wdata,
  output logic [NumLanes-1:0] o_st_wstrb,
  input  logic [1:0]          i_ld_addr_lo,
  input  logic [1:0]          i_ld_size,
  input  logic                i_ld_unsigned,
  input  logic [DataW-1:0]    i_ld_rdata,
  output logic [DataW-1:0]    o_ld_data
);

  logic [DataW-1:0] w_shifted;

  // Replicating the datum across lanes lets the slave pick any lane by strobe alone.
  always_comb begin
    o_st_wdata = i_st_data;
    o_st_wstrb = '1;
    case (i_st_size)
      SZ_B: begin
        o_st_wdata = {4{i_st_data[7:0]}};
        o_st_wstrb = 4'b0001 << i_st_addr_lo;
      end
      SZ_H: begin
        o_st_wdata = {2{i_st_data[15:0]}};
        o_st_wstrb = 4'b0011 << {i_st_addr_lo[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign w_shifted = i_ld_rdata >> {i_ld_addr_lo, 3'b000};

  always_comb begin
    o_ld_data = w_shifted;
    case (i_ld_size)
      SZ_B: o_ld_data = i_ld_unsigned ? {24'b0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H: o_ld_data = i_ld_unsigned ? {16'b0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: memory-access stage downstream of execute. One instruction in flight.
//   clk, rst            clock, synchronous active-high reset
//   in_*                execute result (valid/ready), captured only in IDLE
//   mem                 data bus (lsu_stage_if.master), at most one request per instruction
//   out_*               writeback message (valid/ready), held stable in DONE
// Non-memory and misaligned ops go IDLE -> DONE; aligned loads/stores IDLE -> REQ -> WAIT -> DONE.
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_alu_result,
  input  logic [WIDTH-1:0] in_store_data,
  input  logic [4:0]       in_rf_waddr,
  input  logic             in_rf_we,
  input  logic             in_mem_re,
  input  logic             in_mem_we,
  input  logic [1:0]       in_mem_size,
  input  logic             in_mem_unsigned,
  input  logic [WIDTH-1:0] in_pc,
  lsu_stage_if.master      mem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rf_waddr,
  output logic             out_rf_we,
  output logic [WIDTH-1:0] out_rf_wdata,
  output logic [WIDTH-1:0] out_pc,
  output logic             out_misalign
);

  lsu_state_e r_state, w_state_next;

  logic [WIDTH-1:0]   r_req_addr;
  logic               r_req_wen;
  logic [WIDTH-1:0]   r_req_wdata;
  logic [WIDTH/8-1:0] r_req_wstrb;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [4:0]         r_out_rf_waddr;
  logic               r_out_rf_we;
  logic [WIDTH-1:0]   r_out_rf_wdata;
  logic [WIDTH-1:0]   r_out_pc;
  logic               r_out_misalign;

  logic               w_is_mem;
  logic               w_misalign;
  logic               w_in_hs;
  logic               w_rsp_hs;
  logic [WIDTH-1:0]   w_st_wdata;
  logic [WIDTH/8-1:0] w_st_wstrb;
  logic [WIDTH-1:0]   w_ld_data;

  assign w_is_mem   = in_mem_re | in_mem_we;
  assign w_misalign = w_is_mem & is_misaligned(in_mem_size, in_alu_result[1:0]);
  assign w_in_hs    = in_valid & (r_state == StIdle);
  assign w_rsp_hs   = mem.mem_rsp_valid & (r_state == StWait);

  lsu_align u_align (
    .i_st_addr_lo  (in_alu_result[1:0]),
    .i_st_size     (in_mem_size),
    .i_st_data     (in_store_data),
    .o_st_wdata    (w_st_wdata),
    .o_st_wstrb    (w_st_wstrb),
    .i_ld_addr_lo  (r_req_addr[1:0]),
    .i_ld_size     (r_size),
    .i_ld_unsigned (r_unsigned),
    .i_ld_rdata    (mem.mem_rsp_rdata),
    .o_ld_data     (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (in_valid) w_state_next = (w_is_mem && !w_misalign) ? StReq : StDone;
      StReq:  if (mem.mem_req_ready) w_state_next = StWait;
      StWait: if (mem.mem_rsp_valid) w_state_next = StDone;
      StDone: if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    in_ready          = (r_state == StIdle);
    mem.mem_req_valid = (r_state == StReq);
    out_valid         = (r_state == StDone);
  end

  // Store formatting is done at capture so the request is stable for the whole REQ stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_addr     <= '0;
      r_req_wen      <= 1'b0;
      r_req_wdata    <= '0;
      r_req_wstrb    <= '0;
      r_size         <= 2'b00;
      r_unsigned     <= 1'b0;
      r_out_rf_waddr <= 5'd0;
      r_out_rf_we    <= 1'b0;
      r_out_rf_wdata <= '0;
      r_out_pc       <= '0;
      r_out_misalign <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_req_addr     <= in_alu_result;
        r_req_wen      <= in_mem_we;
        r_req_wdata    <= w_st_wdata;
        r_req_wstrb    <= in_mem_we ? w_st_wstrb : '0;
        r_size         <= in_mem_size;
        r_unsigned     <= in_mem_unsigned;
        r_out_rf_waddr <= in_rf_waddr;
        r_out_rf_we    <= in_rf_we & ~w_misalign;
        r_out_rf_wdata <= w_is_mem ? '0 : in_alu_result;
        r_out_pc       <= in_pc;
        r_out_misalign <= w_misalign;
      end
      if (w_rsp_hs) begin
        if (r_req_wen) begin
          r_out_rf_we <= 1'b0;
        end else begin
          r_out_rf_wdata <= w_ld_data;
        end
      end
    end
  end

  assign mem.mem_req_addr  = r_req_addr;
  assign mem.mem_req_wen   = r_req_wen;
  assign mem.mem_req_wdata = r_req_wdata;
  assign mem.mem_req_wstrb = r_req_wstrb;

  assign out_rf_waddr = r_out_rf_waddr;
  assign out_rf_we    = r_out_rf_we;
  assign out_rf_wdata = r_out_rf_wdata;
  assign out_pc       = r_out_pc;
  assign out_misalign = r_out_misalign;

endmodule
